fast_cmd_scheduler: RTL and testbench
=====================================

Name: fast_cmd_scheduler

Overview:
Generates and arbitrates the ETROC2 fast-command stream (4-bit fc codes) for one clock domain.
- Runs a free-running orbit (BX) counter and emits BCR once per orbit.
- Sequences programmable charge-injection → L1A bursts.
- Merges external L1A and link-reset requests into a single registered fc output, one code per clock.
- Sits ahead of the fast-command serializer and replaces ad-hoc per-command session generators.

Parameters:
- ORBIT_LEN, 3564, BX clocks per orbit.
- BXW, 12, width of the BX counter and BX-position inputs.
- DLYW, 8, width of the injection-to-L1A delay.
- REPW, 8, width of the burst repeat count.

Ports:
- clk  in  1  40 MHz fast-command clock.
- rstn  in  1  reset; asynchronous, active-low.
- enable  in  1  run control; low holds the BX counter at 0 and aborts any burst.
- bcr_offset  in  BXW  BX position at which BCR is issued.
- linkreset_req  in  1  one-cycle pulse requesting a linkReset.
- ext_l1a  in  1  one-cycle external trigger pulse.
- qinj_req  in  1  one-cycle pulse starting an injection burst; ignored while busy.
- qinj_bx  in  BXW  BX position of each injection.
- qinj_dly  in  DLYW  clocks from issued chargeInj to its L1A.
- qinj_repeat  in  REPW  number of injections, one per orbit.
- fc_cmd  out  4  registered fast command.
- bx_cnt  out  BXW  current BX counter.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when a burst completes normally.

Behaviour:
- Codes: idle=0, linkReset=1, BCR=2, chargeInj=5, L1A=6, L1A_BCR=7.
- Reset (async, rstn=0): fc_cmd=0, bx_cnt=0, busy=0, done=0, FSM=IDLE, all pending flags cleared.
- BX counter:
  - While enable=1, increments each clk and wraps from ORBIT_LEN-1 to 0.
  - While enable=0, held at 0.
  - Not affected by linkReset.
- BCR request is asserted when enable=1 and bx_cnt==bcr_offset.
  - bcr_offset ≥ ORBIT_LEN → BCR is never issued.
- linkreset_req sets a pending flag; the flag clears when linkReset is granted.
- FSM:
  - IDLE: on qinj_req with enable=1:
    - Latch qinj_bx, qinj_dly (0 is coerced to 1) and qinj_repeat (0 is coerced to 1) into rem.
    - Set busy=1 and go to ARMED.
  - ARMED: when bx_cnt==latched qinj_bx → INJ.
  - INJ: requests chargeInj.
    - On grant, load the delay counter with dly and go to WAIT.
    - If not granted, stay in INJ; the chargeInj is deferred, not dropped.
  - WAIT: decrement the delay counter each clk; at 1 → L1A.
  - L1A: requests L1A until granted. On grant, rem decrements:
    - rem becomes 0 → done=1 for one clk, busy=0, go to IDLE.
    - Otherwise → ARMED (next orbit).
  - enable=0 in any state: go to IDLE next clk, busy=0, done stays 0.
- Arbitration (combinational select, registered into fc_cmd; fc_cmd reflects requests present at the previous edge, 1-clk latency):
  1. linkReset pending → 1. BCR, L1A and chargeInj wait; a BCR pulse coinciding with linkReset is lost.
  2. BCR together with any L1A (ext_l1a or FSM L1A) → 7; both are served.
  3. BCR alone → 2.
  4. Any L1A → 6. ext_l1a and FSM L1A in the same clk produce a single code and both are served.
  5. chargeInj → 5.
  6. Otherwise → 0.
- ext_l1a is not queued: a pulse coinciding with linkReset is dropped.
- FSM L1A delay counts from the clk its chargeInj was granted. If the L1A is deferred by linkReset, the delay grows by the deferral.
- qinj_req while busy: ignored, no state change.
- qinj_bx ≥ ORBIT_LEN: the burst never fires. Clear it with enable=0.

Test Plan:
- Reset, then enable=1, bcr_offset=100 → fc_cmd=2 exactly once per 3564 clks, first appearing 1 clk after bx_cnt==100; all other clks 0.
- qinj_req with qinj_bx=500, dly=20, repeat=3 → three orbits each show 5 (1 clk after bx_cnt==500) then 6 twenty clks later; done pulses after the third L1A; busy falls the same clk.
- bcr_offset=520, qinj_bx=500, dly=20 → the L1A coincides with BCR → single 7 at that slot, no separate 2 or 6.
- linkreset_req and ext_l1a pulsed in the same clk → fc_cmd=1 for one clk; the external L1A never appears.
- qinj_bx=bcr_offset=300 → BCR (2) at the slot, 5 on the next clk, L1A dly clks after that 5.
- Mid-burst (WAIT state) deassert enable → busy=0 next clk, no L1A emitted, no done, bx_cnt=0; assert rstn=0 asynchronously mid-orbit → fc_cmd=0 immediately.

Source files
------------

// File: rtl/fast_cmd_scheduler.sv
// ETROC2 fast-command scheduler: free-running orbit counter, once-per-orbit BCR,
// charge-injection -> L1A burst sequencer and a fixed-priority merge of every
// fast-command source into a single registered 4-bit code per clock.
module fast_cmd_scheduler #(
    parameter int unsigned ORBIT_LEN = 3564,
    parameter int unsigned BXW       = 12,
    parameter int unsigned DLYW      = 8,
    parameter int unsigned REPW      = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            enable,
    input  logic [BXW-1:0]  bcr_offset,
    input  logic            linkreset_req,
    input  logic            ext_l1a,
    input  logic            qinj_req,
    input  logic [BXW-1:0]  qinj_bx,
    input  logic [DLYW-1:0] qinj_dly,
    input  logic [REPW-1:0] qinj_repeat,
    output logic [3:0]      fc_cmd,
    output logic [BXW-1:0]  bx_cnt,
    output logic            busy,
    output logic            done
);

    localparam logic [3:0] FC_IDLE      = 4'd0;
    localparam logic [3:0] FC_LINKRESET = 4'd1;
    localparam logic [3:0] FC_BCR       = 4'd2;
    localparam logic [3:0] FC_QINJ      = 4'd5;
    localparam logic [3:0] FC_L1A       = 4'd6;
    localparam logic [3:0] FC_L1A_BCR   = 4'd7;

    localparam logic [BXW-1:0] BX_LAST = BXW'(ORBIT_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_INJ,
        S_WAIT,
        S_L1A
    } state_t;

    state_t          state, state_next;
    logic [BXW-1:0]  bx_next;
    logic [BXW-1:0]  inj_bx, inj_bx_next;
    logic [DLYW-1:0] inj_dly, inj_dly_next;
    logic [DLYW-1:0] dly_cnt, dly_cnt_next;
    logic [REPW-1:0] rem, rem_next;
    logic            lr_pend, lr_pend_next;
    logic            done_next;
    logic [3:0]      fc_next;

    logic            lr_req, bcr_req, inj_match, inj_req, fsm_l1a_req, any_l1a;
    logic            lr_grant, inj_grant, l1a_grant;

    // Orbit counter: wraps at the orbit length, parked at 0 while disabled
    always_comb begin
        bx_next = '0;
        if (enable) begin
            bx_next = (bx_cnt == BX_LAST) ? '0 : bx_cnt + BXW'(1);
        end
    end

    // Request collection and fixed-priority selection of the next fast command
    always_comb begin
        lr_req      = lr_pend | linkreset_req;
        bcr_req     = enable & (bx_cnt == bcr_offset);
        // an armed burst requests its chargeInj in the very clock its slot comes up
        inj_match   = enable & (state == S_ARMED) & (bx_cnt == inj_bx);
        inj_req     = inj_match | (enable & (state == S_INJ));
        fsm_l1a_req = enable & (state == S_L1A);
        any_l1a     = ext_l1a | fsm_l1a_req;

        fc_next   = FC_IDLE;
        lr_grant  = 1'b0;
        inj_grant = 1'b0;
        l1a_grant = 1'b0;
        if (lr_req) begin
            fc_next  = FC_LINKRESET;
            lr_grant = 1'b1;
        end else if (bcr_req && any_l1a) begin
            fc_next   = FC_L1A_BCR;
            l1a_grant = fsm_l1a_req;
        end else if (bcr_req) begin
            fc_next = FC_BCR;
        end else if (any_l1a) begin
            fc_next   = FC_L1A;
            l1a_grant = fsm_l1a_req;
        end else if (inj_req) begin
            fc_next   = FC_QINJ;
            inj_grant = 1'b1;
        end
        lr_pend_next = lr_req & ~lr_grant;
    end

    // Burst sequencer next-state: arm, inject, wait the delay, trigger, repeat
    always_comb begin
        state_next   = state;
        inj_bx_next  = inj_bx;
        inj_dly_next = inj_dly;
        dly_cnt_next = dly_cnt;
        rem_next     = rem;
        done_next    = 1'b0;
        if (!enable) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (qinj_req) begin
                        inj_bx_next  = qinj_bx;
                        inj_dly_next = (qinj_dly == '0) ? DLYW'(1) : qinj_dly;
                        rem_next     = (qinj_repeat == '0) ? REPW'(1) : qinj_repeat;
                        state_next   = S_ARMED;
                    end
                end
                S_ARMED, S_INJ: begin
                    if (inj_grant) begin
                        // L1A is due inj_dly clocks after the granted chargeInj
                        dly_cnt_next = inj_dly;
                        state_next   = (inj_dly == DLYW'(1)) ? S_L1A : S_WAIT;
                    end else if (inj_match) begin
                        state_next = S_INJ;
                    end
                end
                S_WAIT: begin
                    dly_cnt_next = dly_cnt - DLYW'(1);
                    if (dly_cnt <= DLYW'(2)) begin
                        state_next = S_L1A;
                    end
                end
                S_L1A: begin
                    if (l1a_grant) begin
                        rem_next = rem - REPW'(1);
                        if (rem == REPW'(1)) begin
                            done_next  = 1'b1;
                            state_next = S_IDLE;
                        end else begin
                            state_next = S_ARMED;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            bx_cnt  <= '0;
            inj_bx  <= '0;
            inj_dly <= '0;
            dly_cnt <= '0;
            rem     <= '0;
            lr_pend <= 1'b0;
            fc_cmd  <= FC_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            bx_cnt  <= bx_next;
            inj_bx  <= inj_bx_next;
            inj_dly <= inj_dly_next;
            dly_cnt <= dly_cnt_next;
            rem     <= rem_next;
            lr_pend <= lr_pend_next;
            fc_cmd  <= fc_next;
            busy    <= (state_next != S_IDLE);
            done    <= done_next;
        end
    end

endmodule

// File: tb/tb_fast_cmd_scheduler.sv
// Self-checking bench for fast_cmd_scheduler: directed scenarios plus random
// traffic, all checked against a timestamp-based behavioural model.
module tb_fast_cmd_scheduler;

    localparam int ORBIT = 3564;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [11:0] bcr_offset;
    logic        linkreset_req;
    logic        ext_l1a;
    logic        qinj_req;
    logic [11:0] qinj_bx;
    logic [7:0]  qinj_dly;
    logic [7:0]  qinj_repeat;
    logic [3:0]  fc_cmd;
    logic [11:0] bx_cnt;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    // model state: burst described by phase and absolute L1A due time
    int     m_bx;
    bit     m_active;
    int     m_phase;      // 0 waiting for slot, 1 chargeInj owed, 2 L1A scheduled
    int     m_inj_bx, m_dly, m_rem;
    longint m_cyc, m_t_l1a;
    int     exp_fc;
    bit     exp_busy, exp_done;

    fast_cmd_scheduler dut (
        .clk(clk), .rstn(rstn), .enable(enable), .bcr_offset(bcr_offset),
        .linkreset_req(linkreset_req), .ext_l1a(ext_l1a), .qinj_req(qinj_req),
        .qinj_bx(qinj_bx), .qinj_dly(qinj_dly), .qinj_repeat(qinj_repeat),
        .fc_cmd(fc_cmd), .bx_cnt(bx_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_bx = 0; m_active = 0; m_phase = 0; m_rem = 0; m_dly = 1; m_inj_bx = 0;
        m_cyc = 0; m_t_l1a = 0; exp_fc = 0; exp_busy = 0; exp_done = 0;
    endtask

    // Predict what the clock edge about to happen produces, from the current inputs
    task automatic model_step();
        bit bcr, lr, inj_w, l1a_w, l1a_any, inj_g, l1a_g;
        bcr     = enable && (m_bx == int'(bcr_offset));
        lr      = linkreset_req;  // top priority: never left waiting
        inj_w   = enable && m_active && (m_phase == 1 || (m_phase == 0 && m_bx == m_inj_bx));
        l1a_w   = enable && m_active && m_phase == 2 && m_cyc >= m_t_l1a;
        l1a_any = ext_l1a || l1a_w;
        inj_g = 0; l1a_g = 0;
        if (lr)                    exp_fc = 1;
        else if (bcr && l1a_any) begin exp_fc = 7; l1a_g = l1a_w; end
        else if (bcr)              exp_fc = 2;
        else if (l1a_any)    begin exp_fc = 6; l1a_g = l1a_w; end
        else if (inj_w)      begin exp_fc = 5; inj_g = 1; end
        else                       exp_fc = 0;
        exp_done = 0;
        if (!enable) begin
            m_active = 0; m_phase = 0;
        end else if (!m_active) begin
            if (qinj_req) begin
                m_active = 1; m_phase = 0; m_inj_bx = int'(qinj_bx);
                m_dly = (qinj_dly == 0) ? 1 : int'(qinj_dly);
                m_rem = (qinj_repeat == 0) ? 1 : int'(qinj_repeat);
            end
        end else begin
            if (inj_g) begin m_phase = 2; m_t_l1a = m_cyc + m_dly; end
            else if (inj_w) m_phase = 1;
            if (l1a_g) begin
                m_rem--;
                if (m_rem == 0) begin m_active = 0; exp_done = 1; end
                else m_phase = 0;
            end
        end
        exp_busy = m_active;
        m_bx = enable ? (m_bx + 1) % ORBIT : 0;
        m_cyc++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; enable = 0; linkreset_req = 0; ext_l1a = 0; qinj_req = 0;
        bcr_offset = 12'd4000; qinj_bx = 0; qinj_dly = 0; qinj_repeat = 0;
        model_reset();
        #23;
        tests++; if (fc_cmd !== 4'd0) begin fails++; $display("FAIL reset fc_cmd: got %0d want 0", fc_cmd); end
        tests++; if (bx_cnt !== 12'd0) begin fails++; $display("FAIL reset bx_cnt: got %0d want 0", bx_cnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %0b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset done: got %0b want 0", done); end
        @(posedge clk); #1; rstn = 1'b1;
    endtask

    task automatic test_bcr();
        int twos = 0;
        bcr_offset = 12'd100; enable = 1;
        for (int i = 0; i < 2 * ORBIT; i++) begin
            tick();
            tests++; if (fc_cmd !== 4'(exp_fc)) begin fails++; $display("FAIL bcr fc_cmd: got %0d want %0d cyc %0d", fc_cmd, exp_fc, m_cyc); end
            tests++; if (bx_cnt !== 12'(m_bx)) begin fails++; $display("FAIL bcr bx_cnt: got %0d want %0d", bx_cnt, m_bx); end
            if (fc_cmd == 4'd2) begin
                twos++;
                tests++; if (bx_cnt !== 12'd101) begin fails++; $display("FAIL bcr slot: bx %0d want 101", bx_cnt); end
            end
        end
        tests++; if (twos != 2) begin fails++; $display("FAIL bcr count: got %0d want 2", twos); end
    endtask

    task automatic test_burst();
        int fives = 0, sixes = 0, dones = 0;
        qinj_bx = 12'd500; qinj_dly = 8'd20; qinj_repeat = 8'd3; qinj_req = 1;
        tick(); qinj_req = 0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL burst busy rise: got %0b want 1", busy); end
        for (int i = 0; i < 3 * ORBIT + 100; i++) begin
            tick();
            tests++; if (fc_cmd !== 4'(exp_fc)) begin fails++; $display("FAIL burst fc_cmd: got %0d want %0d cyc %0d", fc_cmd, exp_fc, m_cyc); end
            tests++; if (busy !== exp_busy) begin fails++; $display("FAIL burst busy: got %0b want %0b", busy, exp_busy); end
            tests++; if (done !== exp_done) begin fails++; $display("FAIL burst done: got %0b want %0b", done, exp_done); end
            if (fc_cmd == 4'd5) begin
                fives++;
                tests++; if (bx_cnt !== 12'd501) begin fails++; $display("FAIL burst inj slot: bx %0d want 501", bx_cnt); end
            end
            if (fc_cmd == 4'd6) begin
                sixes++;
                tests++; if (bx_cnt !== 12'd521) begin fails++; $display("FAIL burst l1a slot: bx %0d want 521", bx_cnt); end
            end
            if (done === 1'b1) begin
                dones++;
                tests++; if (fc_cmd !== 4'd6 || busy !== 1'b0) begin fails++; $display("FAIL burst done edge: fc %0d busy %0b want 6/0", fc_cmd, busy); end
            end
        end
        tests++; if (fives != 3 || sixes != 3 || dones != 1) begin fails++; $display("FAIL burst counts: inj %0d l1a %0d done %0d want 3/3/1", fives, sixes, dones); end
    endtask

    task automatic test_coincide();
        int fives = 0, sixes = 0, sevens = 0;
        bcr_offset = 12'd520; qinj_bx = 12'd500; qinj_dly = 8'd20; qinj_repeat = 8'd1; qinj_req = 1;
        tick(); qinj_req = 0;
        for (int i = 0; i < ORBIT + 100; i++) begin
            tick();
            tests++; if (fc_cmd !== 4'(exp_fc)) begin fails++; $display("FAIL coincide fc_cmd: got %0d want %0d cyc %0d", fc_cmd, exp_fc, m_cyc); end
            if (fc_cmd == 4'd5) fives++;
            if (fc_cmd == 4'd6) sixes++;
            if (fc_cmd == 4'd7) begin
                sevens++;
                tests++; if (bx_cnt !== 12'd521) begin fails++; $display("FAIL coincide slot: bx %0d want 521", bx_cnt); end
            end
        end
        tests++; if (fives != 1 || sixes != 0 || sevens != 1) begin fails++; $display("FAIL coincide counts: inj %0d l1a %0d l1a_bcr %0d want 1/0/1", fives, sixes, sevens); end
    endtask

    task automatic test_lr_ext();
        int sixes = 0;
        bcr_offset = 12'd4000;
        linkreset_req = 1; ext_l1a = 1;
        tick(); linkreset_req = 0; ext_l1a = 0;
        tests++; if (fc_cmd !== 4'd1) begin fails++; $display("FAIL lr_ext code: got %0d want 1", fc_cmd); end
        tick();
        tests++; if (fc_cmd !== 4'd0) begin fails++; $display("FAIL lr_ext after: got %0d want 0", fc_cmd); end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (fc_cmd == 4'd6) sixes++;
            tests++; if (fc_cmd !== 4'(exp_fc)) begin fails++; $display("FAIL lr_ext fc_cmd: got %0d want %0d", fc_cmd, exp_fc); end
        end
        tests++; if (sixes != 0) begin fails++; $display("FAIL lr_ext dropped l1a: got %0d want 0", sixes); end
    endtask

    task automatic test_same_slot();
        int bx5 = -1, bx6 = -1, prev5 = -1;
        logic [3:0] prev = 4'd0;
        bcr_offset = 12'd300; qinj_bx = 12'd300; qinj_dly = 8'd5; qinj_repeat = 8'd1; qinj_req = 1;
        tick(); qinj_req = 0;
        for (int i = 0; i < ORBIT + 50; i++) begin
            tick();
            tests++; if (fc_cmd !== 4'(exp_fc)) begin fails++; $display("FAIL same_slot fc_cmd: got %0d want %0d cyc %0d", fc_cmd, exp_fc, m_cyc); end
            if (fc_cmd == 4'd5) begin bx5 = int'(bx_cnt); prev5 = int'(prev); end
            if (fc_cmd == 4'd6) bx6 = int'(bx_cnt);
            prev = fc_cmd;
        end
        tests++; if (prev5 != 2 || bx5 != 302) begin fails++; $display("FAIL same_slot inj: bx %0d prev %0d want 302/2", bx5, prev5); end
        tests++; if (bx6 != 307) begin fails++; $display("FAIL same_slot l1a: bx %0d want 307", bx6); end
    endtask

    task automatic test_abort();
        int guard = 0, sixes = 0, dones = 0;
        bcr_offset = 12'd4000; qinj_bx = 12'd500; qinj_dly = 8'd20; qinj_repeat = 8'd2; qinj_req = 1;
        tick(); qinj_req = 0;
        while (exp_fc != 5 && guard < ORBIT + 10) begin tick(); guard++; end
        tests++; if (fc_cmd !== 4'd5) begin fails++; $display("FAIL abort inj seen: got %0d want 5", fc_cmd); end
        repeat (5) tick();
        enable = 0;
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort busy: got %0b want 0", busy); end
        tests++; if (bx_cnt !== 12'd0) begin fails++; $display("FAIL abort bx_cnt: got %0d want 0", bx_cnt); end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (fc_cmd == 4'd6) sixes++;
            if (done === 1'b1) dones++;
        end
        tests++; if (sixes != 0 || dones != 0) begin fails++; $display("FAIL abort leftovers: l1a %0d done %0d want 0/0", sixes, dones); end
        enable = 1;
    endtask

    task automatic test_random();
        int en_hold = 0;
        for (int i = 0; i < 20000; i++) begin
            if (i % 1000 == 0)
                bcr_offset = ($urandom_range(0, 7) == 0) ? 12'd4000 : 12'($urandom_range(0, ORBIT - 1));
            ext_l1a       = ($urandom_range(0, 39) == 0);
            linkreset_req = ($urandom_range(0, 59) == 0);
            qinj_req      = ($urandom_range(0, 149) == 0);
            qinj_bx       = ($urandom_range(0, 9) == 0) ? 12'd4000
                          : 12'((m_bx + int'($urandom_range(2, 80))) % ORBIT);
            qinj_dly      = 8'($urandom_range(0, 40));
            qinj_repeat   = 8'($urandom_range(0, 2));
            if (en_hold > 0) begin en_hold--; enable = 0; end
            else begin
                enable = 1;
                if ($urandom_range(0, 1999) == 0) en_hold = int'($urandom_range(1, 4));
            end
            tick();
            tests++; if (fc_cmd !== 4'(exp_fc)) begin fails++; $display("FAIL random fc_cmd: got %0d want %0d cyc %0d", fc_cmd, exp_fc, m_cyc); end
            tests++; if (bx_cnt !== 12'(m_bx)) begin fails++; $display("FAIL random bx_cnt: got %0d want %0d", bx_cnt, m_bx); end
            tests++; if (busy !== exp_busy) begin fails++; $display("FAIL random busy: got %0b want %0b cyc %0d", busy, exp_busy, m_cyc); end
            tests++; if (done !== exp_done) begin fails++; $display("FAIL random done: got %0b want %0b cyc %0d", done, exp_done, m_cyc); end
        end
        ext_l1a = 0; linkreset_req = 0; qinj_req = 0; enable = 1;
    endtask

    task automatic test_async_reset();
        int guard = 0;
        enable = 1; bcr_offset = 12'd100;
        qinj_bx = 12'd3000; qinj_dly = 8'd3; qinj_repeat = 8'd1; qinj_req = 1;
        tick(); qinj_req = 0;
        while (exp_fc != 2 && guard < ORBIT + 10) begin tick(); guard++; end
        tests++; if (fc_cmd !== 4'd2 || busy !== 1'b1) begin fails++; $display("FAIL async pre: fc %0d busy %0b want 2/1", fc_cmd, busy); end
        #2 rstn = 1'b0;
        #1;
        tests++; if (fc_cmd !== 4'd0) begin fails++; $display("FAIL async fc_cmd: got %0d want 0", fc_cmd); end
        tests++; if (bx_cnt !== 12'd0 || busy !== 1'b0) begin fails++; $display("FAIL async state: bx %0d busy %0b want 0/0", bx_cnt, busy); end
        model_reset();
        @(posedge clk); #1; rstn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_bcr();
        test_burst();
        test_coincide();
        test_lr_ext();
        test_same_slot();
        test_abort();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
